// File: rtl/kv_csa_acc_pkg.sv
// Shared constants for the CSA accumulator sequencer:
// FSM state encoding and pair-counter limits.
package kv_csa_acc_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_OUT     = 2'd3;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/kv_csa_acc_seq_csa4_2.sv
// 4:2 compressor built from two chained 3:2 rows.
// sum + 2*carry equals in1+in2+in3+in4 exactly.
module kv_csa4_2 #(
    parameter int CSA_WIDTH = 24
) (
    input  logic [CSA_WIDTH-1:0] in1_i,
    input  logic [CSA_WIDTH-1:0] in2_i,
    input  logic [CSA_WIDTH-1:0] in3_i,
    input  logic [CSA_WIDTH-1:0] in4_i,
    output logic [CSA_WIDTH:0]   sum_o,
    output logic [CSA_WIDTH-1:0] carry_o
);

    logic [CSA_WIDTH-1:0] s1;
    logic [CSA_WIDTH-1:0] cout;
    logic [CSA_WIDTH-1:0] cin;

    assign s1   = in1_i ^ in2_i ^ in3_i;
    assign cout = (in1_i & in2_i) | (in1_i & in3_i) | (in2_i & in3_i);
    // First-row carries enter the second row one bit up; the top one is kept in sum_o
    assign cin  = {cout[CSA_WIDTH-2:0], 1'b0};

    assign sum_o   = {cout[CSA_WIDTH-1], s1 ^ in4_i ^ cin};
    assign carry_o = (s1 & in4_i) | (s1 & cin) | (in4_i & cin);

endmodule

// File: rtl/kv_csa_acc_seq.sv
// Iterative multi-operand accumulator: folds operand pairs into a
// redundant sum/carry state, then resolves with one carry-propagate add.
module kv_csa_acc_seq
    import kv_csa_acc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     out_cnt,
    output logic                 out_sat
);

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [ACC_WIDTH-1:0] carry_q, carry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic                 out_sat_q, out_sat_d;

    logic [ACC_WIDTH-1:0] ext_a, ext_b;
    logic [ACC_WIDTH-1:0] csa_in1, csa_in2;
    logic [ACC_WIDTH:0]   csa_sum;
    logic [ACC_WIDTH-1:0] csa_carry;
    logic                 accept;
    logic                 unused_csa_top;

    assign ext_a = {{(ACC_WIDTH-WIDTH){in_a[WIDTH-1] & SIGNED}}, in_a};
    assign ext_b = {{(ACC_WIDTH-WIDTH){in_b[WIDTH-1] & SIGNED}}, in_b};

    // A fresh job must not see stale redundant state
    assign csa_in1 = (state_q == ST_IDLE) ? '0 : sum_q;
    assign csa_in2 = (state_q == ST_IDLE) ? '0 : carry_q;

    kv_csa4_2 #(
        .CSA_WIDTH(ACC_WIDTH)
    ) u_csa (
        .in1_i  (csa_in1),
        .in2_i  (csa_in2),
        .in3_i  (ext_a),
        .in4_i  (ext_b),
        .sum_o  (csa_sum),
        .carry_o(csa_carry)
    );

    assign unused_csa_top = csa_sum[ACC_WIDTH] ^ csa_carry[ACC_WIDTH-1];

    assign in_ready  = !reset &&
                       ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    sum_d   = csa_sum[ACC_WIDTH-1:0];
                    carry_d = {csa_carry[ACC_WIDTH-2:0], 1'b0};
                    cnt_d   = (state_q == ST_IDLE) ? 8'd1 : cnt_inc(cnt_q);
                    state_d = in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                out_data_d = sum_q + carry_q;
                out_cnt_d  = cnt_q;
                out_sat_d  = (cnt_q == CNT_MAX);
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sum_q      <= '0;
            carry_q    <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_kv_csa_acc_seq.sv
// Bench for kv_csa_acc_seq: unsigned and signed instances run in lockstep
// on shared stimulus, checked against constants and an arithmetic model.
module tb_kv_csa_acc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_a, in_b;

    logic        in_ready0, out_valid0, out_sat0;
    logic [23:0] out_data0;
    logic [7:0]  out_cnt0;
    logic        in_ready1, out_valid1, out_sat1;
    logic [23:0] out_data1;
    logic [7:0]  out_cnt1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          qg[$];

    typedef struct {
        int          n;
        logic [15:0] a;
        logic [15:0] b;
        int          bub_at;
        int          bub_n;
        logic [23:0] exp_data;
        logic [7:0]  exp_cnt;
        bit          exp_sat;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    kv_csa_acc_seq #(.WIDTH(16), .ACC_WIDTH(24), .SIGNED(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_cnt(out_cnt0), .out_sat(out_sat0)
    );

    kv_csa_acc_seq #(.WIDTH(16), .ACC_WIDTH(24), .SIGNED(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_cnt(out_cnt1), .out_sat(out_sat1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sum of all addends in the queues, mod 2^24
    function automatic logic [23:0] model(input bit sgn);
        longint acc = 0;
        foreach (qa[i]) begin
            acc += sgn ? longint'($signed(qa[i])) : longint'(qa[i]);
            acc += sgn ? longint'($signed(qb[i])) : longint'(qb[i]);
        end
        return acc[23:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [23:0] exp_u, input logic [7:0] exp_cnt,
                           input bit exp_sat, input int hold);
        int n = qa.size();
        logic [23:0] exp_s = model(1'b1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat (qg[i]) tick();
            in_valid = 1'b1;
            in_a     = qa[i];
            in_b     = qb[i];
            in_last  = (i == n - 1);
            chk("beat_in_ready", {in_ready0, in_ready1}, 2'b11);
            tick();
        end
        // Garbage offered during RESOLVE must be ignored
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        chk("resolve_in_ready", {in_ready0, in_ready1}, 2'b00);
        chk("resolve_out_valid", {out_valid0, out_valid1}, 2'b00);
        tick();
        in_valid = 1'b0;
        chk("out_valid_latency", {out_valid0, out_valid1}, 2'b11);
        chk("out_data_u", out_data0, exp_u);
        chk("out_data_s", out_data1, exp_s);
        chk("out_cnt", out_cnt0, exp_cnt);
        chk("out_cnt_s", out_cnt1, exp_cnt);
        chk("out_sat", {out_sat0, out_sat1}, {exp_sat, exp_sat});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_last  = 1'($urandom);
            tick();
            chk("bp_in_ready", {in_ready0, in_ready1}, 2'b00);
            chk("bp_out_valid", {out_valid0, out_valid1}, 2'b11);
            chk("bp_out_data", out_data0, exp_u);
            chk("bp_out_cnt", out_cnt0, exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_in_ready", {in_ready0, in_ready1}, 2'b11);
        chk("idle_out_valid", {out_valid0, out_valid1}, 2'b00);
        qa.delete();
        qb.delete();
        qg.delete();
    endtask

    task automatic push_const(input int n, input logic [15:0] a,
                              input logic [15:0] b, input int bub_at,
                              input int bub_n);
        for (int i = 0; i < n; i++) begin
            qa.push_back(a);
            qb.push_back(b);
            qg.push_back((i == bub_at) ? bub_n : 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1,   16'h0003, 16'h0005, -1, 0, 24'h000008, 8'd1,   1'b0};
        tbl[1] = '{4,   16'hFFFF, 16'hFFFF,  2, 2, 24'h07FFF8, 8'd4,   1'b0};
        tbl[2] = '{2,   16'hFFFF, 16'h0002, -1, 0, 24'h020002, 8'd2,   1'b0};
        tbl[3] = '{254, 16'h0001, 16'h0001, -1, 0, 24'h0001FC, 8'd254, 1'b0};
        tbl[4] = '{255, 16'h0001, 16'h0000, -1, 0, 24'h0000FF, 8'd255, 1'b1};
        tbl[5] = '{256, 16'hFFFF, 16'hFFFF, -1, 0, 24'hFFFE00, 8'd255, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", {in_ready0, in_ready1}, 2'b00);
        chk("rst_out_valid", {out_valid0, out_valid1}, 2'b00);
        chk("rst_out_data", out_data0, 24'h0);
        chk("rst_out_cnt", {out_cnt0, out_sat0}, 9'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {in_ready0, in_ready1}, 2'b11);
        tick();

        foreach (tbl[k]) begin
            push_const(tbl[k].n, tbl[k].a, tbl[k].b, tbl[k].bub_at, tbl[k].bub_n);
            if (k == 2) chk("signed_pair_model", model(1'b1), 24'h000002);
            run_job(tbl[k].exp_data, tbl[k].exp_cnt, tbl[k].exp_sat, 0);
        end

        // Backpressure, then a fresh job must start from zero
        push_const(1, 16'h0010, 16'h0020, -1, 0);
        run_job(24'h000030, 8'd1, 1'b0, 5);
        push_const(1, 16'h0001, 16'h0001, -1, 0);
        run_job(24'h000002, 8'd1, 1'b0, 0);

        // Reset in the middle of an accumulation
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_a     = 16'h1234;
            in_b     = 16'h4321;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("midrst_in_ready", {in_ready0, in_ready1}, 2'b00);
        chk("midrst_out_valid", {out_valid0, out_valid1}, 2'b00);
        chk("midrst_out_data", {out_data0, out_data1}, 48'h0);
        chk("midrst_cnt_sat", {out_cnt0, out_sat0, out_cnt1, out_sat1}, 18'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_release_ready", {in_ready0, in_ready1}, 2'b11);
        tick();
        push_const(1, 16'h0007, 16'h0000, -1, 0);
        run_job(24'h000007, 8'd1, 1'b0, 0);

        // Random jobs against the arithmetic model
        for (int j = 0; j < 25; j++) begin
            int n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                qa.push_back(16'($urandom));
                qb.push_back(16'($urandom));
                qg.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_job(model(1'b0), 8'(n), 1'b0, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
